// File: rtl/contador_segundos_bcd.sv
// rtl/contador_segundos_bcd.sv - 1 Hz BCD seconds counter (up/down, pause, clear) for the 7-segment path
module contador_segundos_bcd #(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int MAX_COUNT   = 59
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       habilitar,
    input  logic       limpiar,
    input  logic       descendente,
    output logic [3:0] segundos_unidades,
    output logic [3:0] segundos_decenas,
    output logic       tick_segundo,
    output logic       fin_cuenta
);

    localparam int             PW       = $clog2(CLK_FREQ_HZ);
    localparam logic [PW-1:0]  PRE_LAST = PW'(CLK_FREQ_HZ - 1);
    localparam logic [3:0]     MAX_T    = 4'(MAX_COUNT / 10);
    localparam logic [3:0]     MAX_U    = 4'(MAX_COUNT % 10);

    logic [PW-1:0] pre;
    logic          step;
    logic          wrap;
    logic [3:0]    u_next;
    logic [3:0]    d_next;

    // limpiar is not folded in here: the register block gives it priority over the step
    assign step = habilitar && (pre == PRE_LAST);

    always_comb begin
        u_next = segundos_unidades;
        d_next = segundos_decenas;
        wrap   = 1'b0;
        if (descendente) begin
            if (segundos_decenas == 4'd0 && segundos_unidades == 4'd0) begin
                d_next = MAX_T;
                u_next = MAX_U;
                wrap   = 1'b1;
            end else if (segundos_unidades == 4'd0) begin
                u_next = 4'd9;
                d_next = segundos_decenas - 4'd1;
            end else begin
                u_next = segundos_unidades - 4'd1;
            end
        end else begin
            if (segundos_decenas == MAX_T && segundos_unidades == MAX_U) begin
                d_next = 4'd0;
                u_next = 4'd0;
                wrap   = 1'b1;
            end else if (segundos_unidades == 4'd9) begin
                u_next = 4'd0;
                d_next = segundos_decenas + 4'd1;
            end else begin
                u_next = segundos_unidades + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pre               <= '0;
            segundos_unidades <= 4'd0;
            segundos_decenas  <= 4'd0;
            tick_segundo      <= 1'b0;
            fin_cuenta        <= 1'b0;
        end else if (limpiar) begin
            pre               <= '0;
            segundos_unidades <= 4'd0;
            segundos_decenas  <= 4'd0;
            tick_segundo      <= 1'b0;
            fin_cuenta        <= 1'b0;
        end else begin
            tick_segundo <= step;
            fin_cuenta   <= step && wrap;
            // Prescaler holds while paused so the second keeps its phase
            if (habilitar) begin
                pre <= (pre == PRE_LAST) ? '0 : pre + 1'b1;
            end
            if (step) begin
                segundos_unidades <= u_next;
                segundos_decenas  <= d_next;
            end
        end
    end

endmodule

// File: doc/contador_segundos_bcd.md
# contador_segundos_bcd

Seconds counter that produces the two BCD digits consumed by the seven-segment display path. It divides the system clock down to a 1 Hz step and counts up or down in BCD between 00 and a configurable maximum, wrapping at either end. It also supports pause and clear. It drives `segundos_unidades` and `segundos_decenas` directly, and exposes per-second and end-of-count pulses for other control logic.

## Interface
- `CLK_FREQ_HZ`, default 50_000_000: clock cycles per counted second; legal range ≥ 2.
- `MAX_COUNT`, default 59: highest displayed value, decimal; legal range 1..99.

- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: one clock; reset is asynchronous and active-low.
- `habilitar` in 1: level; 1 = run, 0 = pause (prescaler and digits hold).
- `limpiar` in 1: synchronous clear; highest priority after reset.
- `descendente` in 1: count direction; 0 = up, 1 = down; sampled on each step edge.
- `segundos_unidades` out 4: units digit, always 0..9.
- `segundos_decenas` out 4: tens digit, always 0..9.
- `tick_segundo` out 1: one-cycle pulse, high in the first cycle the new digit value is visible.
- `fin_cuenta` out 1: one-cycle pulse on wrap (MAX→00 up, 00→MAX down), coincident with `tick_segundo`.

## Operation
- Prescaler:
  - Counts 0..CLK_FREQ_HZ-1; width is $clog2(CLK_FREQ_HZ).
  - Increments only when `habilitar`=1.
  - A step occurs on an edge where prescaler = CLK_FREQ_HZ-1, `habilitar`=1 and `limpiar`=0. The prescaler returns to 0 on that same edge.
- Pause: with `habilitar`=0 the prescaler holds its value, so phase is preserved. The digits hold and no pulses are produced.
- Step, up (`descendente`=0):
  - value = MAX_COUNT → 00, and assert `fin_cuenta`.
  - else if units = 9 → units 0, tens +1.
  - else units +1.
- Step, down (`descendente`=1):
  - value = 00 → MAX_COUNT digits (tens = MAX_COUNT/10, units = MAX_COUNT%10), and assert `fin_cuenta`.
  - else if units = 0 → units 9, tens −1.
  - else units −1.
- Invariant: both digits stay within 0..9 and the value stays within 0..MAX_COUNT. No illegal-code recovery is needed.
- Changing `descendente` between steps takes effect at the next step and does not disturb the prescaler.
- `limpiar`=1 on an edge:
  - prescaler, both digits, `tick_segundo` and `fin_cuenta` go to 0.
  - Applies regardless of `habilitar`.
  - If it coincides with a step, the clear wins: no step and no pulses.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Timing
- Reset (`rst`=0): immediately, asynchronously, digits = 0/0, `tick_segundo` = 0, `fin_cuenta` = 0, prescaler = 0. This holds mid-count as well. Counting resumes from 00 with full prescaler phase after `rst` rises.
- From reset release with `habilitar` held at 1, the first step edge is the CLK_FREQ_HZ-th rising edge. Subsequent steps follow every CLK_FREQ_HZ enabled cycles.
- Step latency: the new digits, `tick_segundo` and `fin_cuenta` all appear after the step edge, in the same cycle, each high for exactly 1 cycle.
- Wrap period up or down: MAX_COUNT+1 steps between `fin_cuenta` pulses.
- After `limpiar`: the first step comes CLK_FREQ_HZ enabled cycles after the clearing edge.

## Test plan
Unless stated, the bench uses CLK_FREQ_HZ=4 and MAX_COUNT=59.

- **Reset:** reset, then habilitar=1.
  - Required: `tick_segundo` every 4 cycles.
  - After 10 ticks, decenas/unidades = 1/0.
  - After 60 ticks = 0/0, with `fin_cuenta` high in the same single cycle as the 60th tick and at no other tick.
- **Pause:** habilitar=1 for 2 cycles after a step, then 0 for 10 cycles, then 1.
  - Required: digits frozen and no pulses during the pause.
  - Next tick after exactly 2 further enabled cycles.
- **Down count:** descendente=1 from 00.
  - Required: the first step gives 5/9 with `fin_cuenta`=1.
  - From 1/0, the next step gives 0/9 with `fin_cuenta`=0.
  - Toggling descendente mid-prescaler does not shift the tick timing.
- **Clear:** `limpiar` asserted on the step edge while at 4/7.
  - Required: 0/0, no `tick_segundo`, no `fin_cuenta`.
  - Next tick 4 enabled cycles later, giving 0/1.
- **Async reset mid-count:** `rst` pulled low asynchronously at 3/2 mid-cycle.
  - Required: outputs 0/0 before the next clock edge, pulses low.
  - Normal counting resumes after release.
- **Max 99:** MAX_COUNT=99, CLK_FREQ_HZ=2, counting up.
  - Required: 9/9 → 0/0 with `fin_cuenta`.
  - Down from 0/0 gives 9/9.
